sub_tb_clk_monitor: RTL and testbench
=====================================

Name: sub_tb_clk_monitor

Overview:
- Synthesizable monitor for the SPI serial clock (sclk, nominal 9 MHz, 50 % duty).
- Samples sclk with a faster reference clock and measures the high time, low time and period in reference-clock cycles.
- Flags frequency, duty-cycle and stuck-clock errors.
- Sits beside the SPI master as a clock-integrity checker feeding status registers.

Parameters:
- CNT_W, 16, width of all duration counters and outputs.
- EXP_PERIOD, 111, expected sclk period in clk cycles (9 MHz at 1 GHz clk).
- PER_TOL, 2, allowed absolute period error in cycles (inclusive).
- DUTY_TOL, 1, allowed absolute difference between high and low time (inclusive).
- TIMEOUT, 1000, cycles without an sclk edge before declaring the clock stuck.

Ports:
- clk  in  1  reference clock; all logic is on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- sclk  in  1  monitored SPI clock; asynchronous to clk.
- high_len  out  CNT_W  last complete high-phase length, in clk cycles.
- low_len  out  CNT_W  last complete low-phase length, in clk cycles.
- period_len  out  CNT_W  high_len + low_len, saturating.
- meas_valid  out  1  one-cycle pulse when a new full period is measured.
- freq_ok  out  1  last period within EXP_PERIOD ± PER_TOL.
- duty_ok  out  1  last period satisfies |high − low| ≤ DUTY_TOL.
- stuck  out  1  no edge for TIMEOUT cycles; cleared by the next edge.
- err_sticky  out  1  set on any meas_valid with freq_ok=0 or duty_ok=0, or on stuck; cleared only by reset.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: all outputs are 0; counters and synchronizer flops are 0; FSM is in IDLE.
- Synchronization and edge detection:
  - sclk passes through a 2-flop synchronizer (s1, s2); a third flop s3 holds the previous value.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - An sclk transition is detected 3 clk cycles after it occurs (± one cycle of sampling uncertainty).
- Phase counter cnt:
  - Loads 1 on any edge; otherwise increments by 1 each cycle.
  - Saturates at 2^CNT_W − 1 and never wraps.
  - cnt therefore equals the number of cycles s2 has held its current level.
- FSM:
  - IDLE: cnt runs; the first edge → ARMED. The partial first phase is discarded.
  - ARMED: on fall, capture high_len = cnt → HALF. A rise in ARMED only reloads cnt and stays in ARMED.
  - HALF: on rise, capture low_len = cnt; compute period, freq_ok and duty_ok; pulse meas_valid → RUN.
  - RUN: on fall, update high_len. On rise, update low_len, recompute, pulse meas_valid.
  - Any state except IDLE: if cnt reaches TIMEOUT → assert stuck, go to IDLE. The length outputs keep their last values.
- stuck deasserts on the next detected edge.
- meas_valid is high only in the cycle after the rise is detected. freq_ok, duty_ok and period_len update in that same cycle.
- Arithmetic:
  - Sums and differences use CNT_W+1 bits internally.
  - period_len saturates at 2^CNT_W − 1.
  - Tolerance comparisons are inclusive, on absolute differences.
- An sclk glitch shorter than 1 clk cycle may be missed; a 1-cycle phase is measured as 1.
- Reset asserted mid-measurement aborts immediately; no meas_valid is generated.

Decomposition:
- Package sub_tb_clk_monitor_pkg holds:
  - the FSM state enum (IDLE, ARMED, HALF, RUN);
  - the default constants (EXP_PERIOD, PER_TOL, DUTY_TOL, TIMEOUT);
  - an abs-difference function.
- One sub-module: sync_edge_det (2-flop synchronizer plus rise/fall detect), reusable for other async inputs.

Test Plan:
- Nominal clock: sclk high 56 / low 55 cycles, repeating → meas_valid once per period from the second rise; high_len=56, low_len=55, period_len=111, freq_ok=1, duty_ok=1, err_sticky=0.
- Slow clock: high 60 / low 60 → period_len=120, freq_ok=0, duty_ok=1, err_sticky=1 and stays 1 after sclk returns to nominal.
- Duty error: high 70 / low 41 → period_len=111, freq_ok=1, duty_ok=0, err_sticky=1.
- Boundary tolerances:
  - high 57 / low 56 (period 113) → freq_ok=1, duty_ok=1.
  - high 57 / low 57 (114) → freq_ok=0.
- Stuck clock: hold sclk=1 for 1200 cycles → stuck=1 exactly TIMEOUT cycles after the last captured edge; err_sticky=1; the first new edge clears stuck; the next valid measurement needs a full high plus low phase.
- Reset mid-phase: assert rst_n=0 during a high phase → next cycle all outputs are 0; after release there is no meas_valid until a complete period follows the first edge.

Source files
------------

// File: rtl/sub_tb_clk_monitor_pkg.sv
// Shared types, default constants and helpers for the SPI clock monitor.
package sub_tb_clk_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HALF,
        RUN
    } state_t;

    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_EXP_PERIOD = 111;
    localparam int unsigned DEF_PER_TOL    = 2;
    localparam int unsigned DEF_DUTY_TOL   = 1;
    localparam int unsigned DEF_TIMEOUT    = 1000;

    // Absolute difference of two unsigned values.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sub_tb_clk_monitor_sync.sv
// Two-flop synchronizer with one history flop and rise/fall detection.
// Reusable for any single-bit asynchronous input.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronize the input and keep the previous synchronized value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Edge flags from the synchronized level and its history.
    always_comb begin
        rise = s2 & ~s3;
        fall = ~s2 & s3;
    end

endmodule

// File: rtl/sub_tb_clk_monitor.sv
// SPI serial clock integrity monitor: measures high/low/period lengths of
// sclk in reference-clock cycles and flags frequency, duty and stuck errors.
module sub_tb_clk_monitor
    import sub_tb_clk_monitor_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int unsigned PER_TOL    = DEF_PER_TOL,
    parameter int unsigned DUTY_TOL   = DEF_DUTY_TOL,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic [CNT_W-1:0] period_len,
    output logic             meas_valid,
    output logic             freq_ok,
    output logic             duty_ok,
    output logic             stuck,
    output logic             err_sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   SUM_MAX = {1'b0, CNT_MAX};
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

    logic             rise;
    logic             fall;
    logic             any_edge;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] period_next;
    logic             freq_next;
    logic             duty_next;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .rise  (rise),
        .fall  (fall)
    );

    assign any_edge = rise | fall;

    // Phase counter: length of the current synchronized level, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (any_edge) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Candidate results for a rise: high_len already holds the high phase,
    // cnt holds the low phase just completed.
    always_comb begin
        sum         = {1'b0, high_len} + {1'b0, cnt};
        period_next = (sum > SUM_MAX) ? CNT_MAX : sum[CNT_W-1:0];
        freq_next   = abs_diff(32'(sum), EXP_PERIOD) <= PER_TOL;
        duty_next   = abs_diff(32'(high_len), 32'(cnt)) <= DUTY_TOL;
    end

    // Measurement FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            high_len   <= '0;
            low_len    <= '0;
            period_len <= '0;
            meas_valid <= 1'b0;
            freq_ok    <= 1'b0;
            duty_ok    <= 1'b0;
            stuck      <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (any_edge) begin
                stuck <= 1'b0;
            end
            if (state != IDLE && !any_edge && cnt >= CNT_TO) begin
                stuck      <= 1'b1;
                err_sticky <= 1'b1;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (any_edge) begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (fall) begin
                            high_len <= cnt;
                            state    <= HALF;
                        end
                    end
                    HALF, RUN: begin
                        if (fall && state == RUN) begin
                            high_len <= cnt;
                        end else if (rise) begin
                            low_len    <= cnt;
                            period_len <= period_next;
                            freq_ok    <= freq_next;
                            duty_ok    <= duty_next;
                            meas_valid <= 1'b1;
                            if (!freq_next || !duty_next) begin
                                err_sticky <= 1'b1;
                            end
                            state <= RUN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sub_tb_clk_monitor.sv
// Directed self-checking bench for the SPI clock monitor.
module tb_sub_tb_clk_monitor;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk  = 1'b0;
    logic [15:0] high_len;
    logic [15:0] low_len;
    logic [15:0] period_len;
    logic        meas_valid;
    logic        freq_ok;
    logic        duty_ok;
    logic        stuck;
    logic        err_sticky;

    int vectors     = 0;
    int miscompares = 0;
    int mv_cnt      = 0;
    int base;
    logic [15:0] cap_high = '0;
    logic [15:0] cap_low  = '0;
    logic [15:0] cap_per  = '0;
    logic        cap_freq = 1'b0;
    logic        cap_duty = 1'b0;

    always #5 clk = ~clk;

    sub_tb_clk_monitor #(
        .CNT_W      (16),
        .EXP_PERIOD (111),
        .PER_TOL    (2),
        .DUTY_TOL   (1),
        .TIMEOUT    (1000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .high_len   (high_len),
        .low_len    (low_len),
        .period_len (period_len),
        .meas_valid (meas_valid),
        .freq_ok    (freq_ok),
        .duty_ok    (duty_ok),
        .stuck      (stuck),
        .err_sticky (err_sticky)
    );

    // Record every measurement pulse and the values reported with it.
    always @(negedge clk) begin
        if (meas_valid) begin
            mv_cnt   = mv_cnt + 1;
            cap_high = high_len;
            cap_low  = low_len;
            cap_per  = period_len;
            cap_freq = freq_ok;
            cap_duty = duty_ok;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        sclk = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic period(input int h, input int l, input int reps);
        for (int i = 0; i < reps; i++) begin
            hold(1'b1, h);
            hold(1'b0, l);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sclk  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(1'b0, 10);
    endtask

    task automatic check_meas(input string tag, input int h, input int l, input int p,
                              input logic f, input logic d);
        check({tag, ".high"}, 32'(cap_high), 32'(h));
        check({tag, ".low"},  32'(cap_low),  32'(l));
        check({tag, ".per"},  32'(cap_per),  32'(p));
        check({tag, ".freq"}, 32'(cap_freq), 32'(f));
        check({tag, ".duty"}, 32'(cap_duty), 32'(d));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".high"},  32'(high_len),   0);
        check({tag, ".low"},   32'(low_len),    0);
        check({tag, ".per"},   32'(period_len), 0);
        check({tag, ".mv"},    32'(meas_valid), 0);
        check({tag, ".freq"},  32'(freq_ok),    0);
        check({tag, ".duty"},  32'(duty_ok),    0);
        check({tag, ".stuck"}, 32'(stuck),      0);
        check({tag, ".err"},   32'(err_sticky), 0);
    endtask

    initial begin
        // Reset state.
        rst_n = 1'b0;
        sclk  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(1'b0, 10);

        // Nominal 56/55.
        base = mv_cnt;
        period(56, 55, 3);
        check("nom.mv_count", 32'(mv_cnt - base), 2);
        check_meas("nom", 56, 55, 111, 1'b1, 1'b1);
        check("nom.err", 32'(err_sticky), 0);
        check("nom.stuck", 32'(stuck), 0);

        // Reset in the middle of a high phase.
        hold(1'b1, 20);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = mv_cnt;
        hold(1'b1, 30);
        hold(1'b0, 55);
        check("midrst.no_mv", 32'(mv_cnt - base), 0);
        period(56, 55, 3);
        check_meas("midrst.after", 56, 55, 111, 1'b1, 1'b1);

        // Duty error 70/41.
        do_reset();
        base = mv_cnt;
        period(70, 41, 3);
        check("duty.mv_count", 32'(mv_cnt - base), 2);
        check_meas("duty", 70, 41, 111, 1'b1, 1'b0);
        check("duty.err", 32'(err_sticky), 1);

        // Slow clock 60/60, then back to nominal: error stays latched.
        do_reset();
        period(60, 60, 3);
        check_meas("slow", 60, 60, 120, 1'b0, 1'b1);
        check("slow.err", 32'(err_sticky), 1);
        period(56, 55, 3);
        check_meas("slow.renom", 56, 55, 111, 1'b1, 1'b1);
        check("slow.renom.err", 32'(err_sticky), 1);

        // Tolerance boundaries.
        do_reset();
        period(57, 56, 3);
        check_meas("bnd113", 57, 56, 113, 1'b1, 1'b1);
        check("bnd113.err", 32'(err_sticky), 0);
        period(57, 57, 3);
        check_meas("bnd114", 57, 57, 114, 1'b0, 1'b1);
        check("bnd114.err", 32'(err_sticky), 1);

        // Stuck clock: rise captured 3 cycles after sclk goes high,
        // stuck follows TIMEOUT cycles after that capture.
        do_reset();
        base = mv_cnt;
        check("stuck.pre_err", 32'(err_sticky), 0);
        sclk = 1'b1;
        repeat (1002) @(posedge clk);
        @(negedge clk);
        check("stuck.before", 32'(stuck), 0);
        @(posedge clk);
        @(negedge clk);
        check("stuck.at_timeout", 32'(stuck), 1);
        check("stuck.err", 32'(err_sticky), 1);
        repeat (197) @(posedge clk);
        #1;
        hold(1'b0, 2);
        check("stuck.hold_until_edge", 32'(stuck), 1);
        hold(1'b0, 1);
        check("stuck.cleared", 32'(stuck), 0);
        hold(1'b0, 52);
        check("stuck.no_mv0", 32'(mv_cnt - base), 0);
        period(56, 55, 1);
        check("stuck.no_mv1", 32'(mv_cnt - base), 0);
        period(56, 55, 1);
        check("stuck.first_mv", 32'(mv_cnt - base), 1);
        check_meas("stuck.recover", 56, 55, 111, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
